fetch_unit: RTL and testbench

Program counter and fetch stage that sits directly upstream of the instruction memory and feeds the decoder.
- Drives current_pc into the combinational instruction memory and captures the returned 9-bit word into a registered output slot.
- Downstream handshake is valid/ready.
- Supports taken-branch/jump redirects and flushes, stops on a halt word, and reports done.

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: PC register plus a registered instruction slot with valid/ready handshake,
// redirect flush and halt detection. Define FETCH_PERF_CNT_EN to add cycle/fetch counters.
module fetch_unit #(
    parameter logic [31:0]        START_PC  = 32'd0,
    parameter int                 INSTR_W   = 9,
    parameter logic [INSTR_W-1:0] HALT_WORD = {INSTR_W{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [31:0]        current_pc,
    input  logic [INSTR_W-1:0] imem_instruction,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    output logic [INSTR_W-1:0] instr_out,
    output logic [31:0]        instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               done
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        cycle_count,
    output logic [31:0]        fetch_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic        slot_free;
    logic        is_halt;
    logic        load_start;
    logic        flush;
    logic        capture;
    logic        drain;
    logic        valid_next;

    assign slot_free  = !instr_valid || instr_ready;
    assign is_halt    = (imem_instruction == HALT_WORD);
    assign current_pc = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Redirect outranks capture, so a halt word under a redirect never ends the program.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (!redirect_valid && slot_free && is_halt) state_next = HALTED;
            HALTED:  if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_start = 1'b0;
        flush      = 1'b0;
        capture    = 1'b0;
        drain      = 1'b0;
        case (state)
            IDLE: load_start = start;
            RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                end else if (slot_free) begin
                    capture = 1'b1;
                end
            end
            HALTED: begin
                if (start) begin
                    load_start = 1'b1;
                end else if (instr_valid && instr_ready) begin
                    drain = 1'b1;
                end
            end
            default: ;
        endcase
        valid_next = instr_valid;
        if (load_start || flush || drain) begin
            valid_next = 1'b0;
        end else if (capture) begin
            valid_next = 1'b1;
        end
    end

    // done looks at next-cycle state so it rises together with the slot emptying.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= 32'd0;
            instr_out   <= '0;
            instr_pc    <= 32'd0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (load_start) begin
                pc <= START_PC;
            end else if (flush) begin
                pc <= redirect_target;
            end else if (capture && !is_halt) begin
                pc <= pc + 32'd1;
            end
            if (capture) begin
                instr_out <= imem_instruction;
                instr_pc  <= pc;
            end
            instr_valid <= valid_next;
            done        <= (state_next == HALTED) && !valid_next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= 32'd0;
            fetch_count <= 32'd0;
        end else if (load_start) begin
            cycle_count <= 32'd0;
            fetch_count <= 32'd0;
        end else begin
            if (state == RUN) cycle_count <= sat_inc(cycle_count);
            if (capture)      fetch_count <= sat_inc(fetch_count);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small instruction memory, an expected-output queue
// drained on every accepted handshake, and directed checks of pc/valid/done behaviour.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] current_pc;
    logic [8:0]  imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [8:0]  instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        done;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cycle_count;
    logic [31:0] fetch_count;
`endif

    typedef struct {
        logic [8:0]  instr;
        logic [31:0] pc;
    } exp_t;

    exp_t       sb_q[$];
    logic [8:0] mem [64];
    int         n_cmp = 0;
    int         n_err = 0;

    fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .current_pc       (current_pc),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .instr_out        (instr_out),
        .instr_pc         (instr_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .done             (done)
`ifdef FETCH_PERF_CNT_EN
        ,
        .cycle_count      (cycle_count),
        .fetch_count      (fetch_count)
`endif
    );

    assign imem_instruction = mem[current_pc[5:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [8:0] instr, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        sb_q.push_back(e);
    endtask

    // Called at a negedge: score any handshake completing this cycle, then advance one cycle.
    task automatic tick();
        exp_t e;
        if (instr_valid && instr_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL sb_unexpected: observed instr %0h pc %0h expected no output", instr_out, instr_pc);
            end else begin
                e = sb_q.pop_front();
                chk("sb_instr", {23'd0, instr_out}, {23'd0, e.instr});
                chk("sb_pc", instr_pc, e.pc);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until_done(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
        chk("done_reached", {31'd0, done}, 32'd1);
        chk("sb_drained", sb_q.size(), 32'd0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 9'h000;
    endtask

    initial begin
        reset           = 1'b0;
        start           = 1'b0;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        clear_mem();
        repeat (2) @(negedge clk);

        chk("rst_pc", current_pc, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_instr", {23'd0, instr_out}, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);

        // Redirect must be ignored in IDLE.
        reset           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h77;
        tick();
        tick();
        chk("idle_redirect_pc", current_pc, 32'd0);
        chk("idle_valid", {31'd0, instr_valid}, 32'd0);
        redirect_valid = 1'b0;

        // Straight-line program ending in a halt word.
        mem[0] = 9'h001;
        mem[1] = 9'h002;
        mem[2] = 9'h1FF;
        push(9'h001, 32'd0);
        push(9'h002, 32'd1);
        push(9'h1FF, 32'd2);
        instr_ready = 1'b1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("start_pc", current_pc, 32'd0);
        chk("start_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("lat_instr", {23'd0, instr_out}, 32'h001);
        chk("lat_pc", instr_pc, 32'd0);
        chk("lat_valid", {31'd0, instr_valid}, 32'd1);
        tick();
        tick();
        chk("halt_pending_done", {31'd0, done}, 32'd0);
        chk("halt_pending_instr", {23'd0, instr_out}, 32'h1FF);
        tick();
        chk("halt_done", {31'd0, done}, 32'd1);
        chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        chk("halt_pc", current_pc, 32'd2);
        chk("halt_sb_empty", sb_q.size(), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_cycles", cycle_count, 32'd3);
        chk("perf_fetches", fetch_count, 32'd3);
`endif

        // Restart from HALTED, then stall mid-stream for three cycles.
        clear_mem();
        for (int i = 0; i < 6; i++) begin
            mem[i] = 9'h010 + 9'(i);
            push(9'h010 + 9'(i), 32'(i));
        end
        mem[6] = 9'h1FF;
        push(9'h1FF, 32'd6);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_done", {31'd0, done}, 32'd0);
        chk("restart_pc", current_pc, 32'd0);
        chk("restart_valid", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("restart_cycles", cycle_count, 32'd0);
        chk("restart_fetches", fetch_count, 32'd0);
`endif
        tick();
        tick();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_instr", {23'd0, instr_out}, 32'h011);
            chk("stall_instr_pc", instr_pc, 32'd1);
            chk("stall_pc", current_pc, 32'd2);
        end
        instr_ready = 1'b1;
        run_until_done(30);
        chk("stall_end_pc", current_pc, 32'd6);

        // Redirect while the slot is stalled flushes it.
        clear_mem();
        mem[0]    = 9'h021;
        mem[1]    = 9'h022;
        mem[6'h20] = 9'h030;
        mem[6'h21] = 9'h1FF;
        push(9'h030, 32'h20);
        push(9'h1FF, 32'h21);
        instr_ready = 1'b0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_flush_valid", {31'd0, instr_valid}, 32'd1);
        chk("pre_flush_pc", current_pc, 32'd1);
        redirect_valid  = 1'b1;
        redirect_target = 32'h20;
        tick();
        redirect_valid = 1'b0;
        chk("flush_valid", {31'd0, instr_valid}, 32'd0);
        chk("flush_pc", current_pc, 32'h20);
        instr_ready = 1'b1;
        tick();
        chk("post_flush_instr_pc", instr_pc, 32'h20);
        chk("post_flush_instr", {23'd0, instr_out}, 32'h030);
        run_until_done(20);
        chk("flush_end_pc", current_pc, 32'h21);

        // Redirect beats a halt word on the same cycle; target exercises pc wrap.
        clear_mem();
        mem[0]  = 9'h1FF;
        mem[63] = 9'h055;
        push(9'h055, 32'hFFFF_FFFF);
        push(9'h1FF, 32'd0);
        start = 1'b1;
        tick();
        start           = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        chk("rdh_valid", {31'd0, instr_valid}, 32'd0);
        chk("rdh_pc", current_pc, 32'hFFFF_FFFF);
        chk("rdh_done", {31'd0, done}, 32'd0);
        tick();
        chk("wrap_pc", current_pc, 32'd0);
        chk("wrap_valid", {31'd0, instr_valid}, 32'd1);
        run_until_done(20);
        chk("wrap_end_pc", current_pc, 32'd0);

        // Asynchronous reset mid-RUN.
        clear_mem();
        for (int i = 0; i < 4; i++) mem[i] = 9'(i + 1);
        push(9'h001, 32'd0);
        push(9'h002, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
        sb_q.delete();
        #2 reset = 1'b0;
        #1;
        chk("arst_pc", current_pc, 32'd0);
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_instr", {23'd0, instr_out}, 32'd0);
        chk("arst_instr_pc", instr_pc, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) tick();
        chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("post_rst_pc", current_pc, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
